conv_unit: RTL and testbench
============================

Name: conv_unit

Overview:
- 5-tap signed dot-product engine for the first 1-D CNN convolution layer of the ECG classifier.
- Computes sum(x_k * w_k) over one 5-sample window and one filter.
- One instance per filter; the layer wrapper shifts and saturates the full-precision result to 8 bits.
- Registered, single-clock, enable-gated.

Parameters:
- DATA_W, 8, width of signed samples and signed weights.
- OUT_W, 19, width of signed accumulated result; must be >= 2*DATA_W+3.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- en  input  1  compute enable; sample operands on this edge.
- in0..in4  input  DATA_W each, signed  window samples x0..x4.
- w0..w4  input  DATA_W each, signed  filter weights; wk pairs with ink.
- quant  output  OUT_W, signed  registered dot product.
- valid  output  1  high for one cycle when quant was updated on the previous edge.

Behaviour:
- Reset (rst=0, asynchronous): quant=0, valid=0 immediately, independent of clk. Both hold while rst is low.
- Reset mid-operation: any pending result is discarded. The first result after rst deasserts needs a new en.
- Compute on a rising edge with rst=1 and en=1:
  - quant <= sign-extend(in0*w0) + ... + sign-extend(in4*w4).
  - valid <= 1.
  - Latency: 1 cycle from operand sampling to quant.
- Rising edge with en=0: quant holds its previous value; valid <= 0.
- Products: full 2*DATA_W signed products (signed x signed), each sign-extended to OUT_W before summing.
- No truncation, rounding or saturation inside this block.
- Range at defaults:
  - min is -81280 (all in=-128, all w=127).
  - max is +81920 (all in=-128, all w=-128).
  - Both fit 19 bits, so no overflow is possible.
- Back-to-back en: a new result every cycle, with no bubbles.
- Operands are combinational inputs, sampled only at the enabling edge. Changes while en=0 have no effect on quant.
- Weights are treated as ordinary inputs; the block holds no weight storage.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_W and the layer-1 OUT_W constants.
  - typedef sample_t (signed [DATA_W-1:0]).
  - typedef acc_t (signed [OUT_W-1:0]).
- The layer wrapper reuses cnn_pkg for its shift amount (7) and its saturation bounds (-127..127).
- No sub-module is needed. The five multipliers and the adder tree sit in one always_comb; one always_ff holds quant and valid.

Test Plan:
- Reset: drive rst=0 with en=1 and nonzero operands; toggle clk -> quant=0 and valid=0 throughout. Deassert rst with en=0 -> quant stays 0.
- Nominal: in0..4=1, w0..4={68,69,27,-86,106}, en pulse for 1 cycle -> quant=184 after 1 edge, valid=1 for 1 cycle, then quant holds 184 with valid=0.
- Extremes:
  - in=-128 all, w=-128 all -> quant=81920.
  - in=-128 all, w=127 all -> quant=-81280.
  - Mixed case in={127,-128,0,1,-1}, w={127,127,5,-128,-128} -> 16129-16256+0-128+128 = -127.
- Hold: after a result, change all operands with en=0 for 5 cycles -> quant unchanged, valid=0.
- Streaming: en=1 for 4 consecutive cycles with windows shifting a ramp 1..8 and w={1,2,3,4,5} -> quant sequence 55,70,85,100, valid=1 each cycle.
- Async reset mid-stream: assert rst low between clock edges during streaming -> quant=0 and valid=0 immediately, without waiting for the edge.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and constants for the ECG classifier CNN layers.
// Layer 1 wrapper also pulls its shift and saturation bounds from here.
package cnn_pkg;

    localparam int DATA_W = 8;
    localparam int L1_OUT_W = 19;
    localparam int N_TAPS = 5;

    localparam int L1_SHIFT = 7;
    localparam int L1_SAT_MAX = 127;
    localparam int L1_SAT_MIN = -127;

    typedef logic signed [DATA_W-1:0] sample_t;
    typedef logic signed [L1_OUT_W-1:0] acc_t;

endpackage

// File: rtl/conv_unit.sv
// 5-tap signed dot product for one filter of the first conv layer.
// Full-precision result, registered once, refreshed only on enabled edges.
module conv_unit
    import cnn_pkg::*;
#(
    parameter int DATA_W = cnn_pkg::DATA_W,
    parameter int OUT_W = cnn_pkg::L1_OUT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] in0,
    input  logic signed [DATA_W-1:0] in1,
    input  logic signed [DATA_W-1:0] in2,
    input  logic signed [DATA_W-1:0] in3,
    input  logic signed [DATA_W-1:0] in4,
    input  logic signed [DATA_W-1:0] w0,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] w2,
    input  logic signed [DATA_W-1:0] w3,
    input  logic signed [DATA_W-1:0] w4,
    output logic signed [OUT_W-1:0]  quant,
    output logic                     valid
);

    localparam int PW = 2 * DATA_W;

    logic signed [DATA_W-1:0] x_v [N_TAPS];
    logic signed [DATA_W-1:0] w_v [N_TAPS];
    logic signed [PW-1:0]     xe;
    logic signed [PW-1:0]     we;
    logic signed [PW-1:0]     prod;
    logic signed [OUT_W-1:0]  sum;

    logic signed [OUT_W-1:0]  quant_d;
    logic signed [OUT_W-1:0]  quant_q;
    logic                     valid_d;
    logic                     valid_q;

    // Widen each tap to a full product, sign-extend and sum.
    always_comb begin
        x_v[0] = in0;
        x_v[1] = in1;
        x_v[2] = in2;
        x_v[3] = in3;
        x_v[4] = in4;
        w_v[0] = w0;
        w_v[1] = w1;
        w_v[2] = w2;
        w_v[3] = w3;
        w_v[4] = w4;
        xe = '0;
        we = '0;
        prod = '0;
        sum = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            xe = {{DATA_W{x_v[k][DATA_W-1]}}, x_v[k]};
            we = {{DATA_W{w_v[k][DATA_W-1]}}, w_v[k]};
            prod = xe * we;
            sum = sum + {{(OUT_W-PW){prod[PW-1]}}, prod};
        end
    end

    // Load a new result on enabled edges, otherwise hold and drop valid.
    always_comb begin
        quant_d = quant_q;
        valid_d = 1'b0;
        if (en) begin
            quant_d = sum;
            valid_d = 1'b1;
        end
    end

    // Result and valid registers; reset clears any pending result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            quant_q <= quant_d;
            valid_q <= valid_d;
        end
    end

    assign quant = quant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_conv_unit.sv
// Directed bench for conv_unit with hand-computed dot products.
// Outputs are sampled 1 time unit after the rising edge.
`timescale 1ns/1ps
module tb_conv_unit;

    logic                clk;
    logic                rst;
    logic                en;
    logic signed [7:0]   in0, in1, in2, in3, in4;
    logic signed [7:0]   w0, w1, w2, w3, w4;
    logic signed [18:0]  quant;
    logic                valid;

    int total;
    int bad;

    conv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .in0   (in0),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .w0    (w0),
        .w1    (w1),
        .w2    (w2),
        .w3    (w3),
        .w4    (w4),
        .quant (quant),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int a0, input int a1, input int a2,
                           input int a3, input int a4,
                           input int b0, input int b1, input int b2,
                           input int b3, input int b4);
        in0 = 8'(a0);
        in1 = 8'(a1);
        in2 = 8'(a2);
        in3 = 8'(a3);
        in4 = 8'(a4);
        w0 = 8'(b0);
        w1 = 8'(b1);
        w2 = 8'(b2);
        w3 = 8'(b3);
        w4 = 8'(b4);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic one_shot(input string tag, input longint exp);
        en = 1'b1;
        step();
        check({tag, "_q"}, quant, exp);
        check({tag, "_v"}, longint'(valid), 1);
        en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        en = 1'b1;
        set_ops(3, -4, 5, 6, 7, 9, 10, -11, 12, 13);

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_q", quant, 0);
            check("rst_v", longint'(valid), 0);
        end
        en = 1'b0;
        #3;
        rst = 1'b1;
        step();
        check("rel_q", quant, 0);
        check("rel_v", longint'(valid), 0);

        set_ops(1, 1, 1, 1, 1, 68, 69, 27, -86, 106);
        one_shot("nom", 184);
        step();
        check("nom_hold_q", quant, 184);
        check("nom_hold_v", longint'(valid), 0);

        set_ops(-128, -128, -128, -128, -128,
                -128, -128, -128, -128, -128);
        one_shot("max", 81920);
        set_ops(-128, -128, -128, -128, -128,
                127, 127, 127, 127, 127);
        one_shot("min", -81280);
        set_ops(127, -128, 0, 1, -1, 127, 127, 5, -128, -128);
        one_shot("mix", -127);

        for (int i = 0; i < 5; i++) begin
            set_ops(i + 20, -i, 50, 7 * i, -90,
                    100, -i - 3, 33, i, 64);
            step();
            check("hold_q", quant, -127);
            check("hold_v", longint'(valid), 0);
        end

        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_ops(i + 1, i + 2, i + 3, i + 4, i + 5, 1, 2, 3, 4, 5);
            step();
            check("strm_q", quant, 55 + 15 * i);
            check("strm_v", longint'(valid), 1);
        end

        set_ops(1, 2, 3, 4, 5, 1, 2, 3, 4, 5);
        step();
        check("ar_pre_q", quant, 55);
        #2;
        rst = 1'b0;
        #1;
        check("ar_q", quant, 0);
        check("ar_v", longint'(valid), 0);
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        check("ar_rel_q", quant, 0);
        check("ar_rel_v", longint'(valid), 0);
        set_ops(2, 2, 2, 2, 2, 1, 1, 1, 1, 1);
        one_shot("ar_new", 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

endmodule
